// File: rtl/riscv_pkg.sv
// riscv_pkg: shared core definitions used by the data-memory controller.
//   - Major opcodes for loads and stores.
//   - dmem_state_t: controller FSM state encoding.
//   - err_cause_t: reason for the last error pulse, exposed for debug.
//   - DMEM_TMR_W: width of the transaction timeout counter.
package riscv_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2,
    DONE     = 2'd3
  } dmem_state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_MISALIGN = 2'd1,
    CAUSE_ILLEGAL  = 2'd2,
    CAUSE_TIMEOUT  = 2'd3
  } err_cause_t;

  // Wide enough for any TIMEOUT in 1..2^16-1.
  localparam int unsigned DMEM_TMR_W = 16;

  // Word accesses only: any set low address bit is a misalignment.
  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return addr_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/riscv_dmem_ctrl_if.sv
// riscv_dmem_ctrl_if: valid/ready data bus between the controller and memory.
//   bus_req_valid / bus_req_ready : request handshake
//   bus_we, bus_addr, bus_wdata    : request payload (stable while valid)
//   bus_rsp_valid, bus_rsp_rdata   : response / ack, used for reads and writes
// Modports: master = controller side, slave = memory side.
interface riscv_dmem_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic              bus_req_valid;
  logic              bus_req_ready;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_rsp_valid;
  logic [DATA_W-1:0] bus_rsp_rdata;

  modport master (
    output bus_req_valid, bus_we, bus_addr, bus_wdata,
    input  bus_req_ready, bus_rsp_valid, bus_rsp_rdata
  );

  modport slave (
    input  bus_req_valid, bus_we, bus_addr, bus_wdata,
    output bus_req_ready, bus_rsp_valid, bus_rsp_rdata
  );

endinterface

// File: rtl/riscv_dmem_timer.sv
// riscv_dmem_timer: loadable up-counter with clear, enable and terminal count.
//   clk, rst : clock, synchronous active-high reset
//   clr      : force count to zero (highest priority)
//   load     : load load_val
//   en       : increment by one
//   limit    : terminal value
//   tc       : high when the next increment reaches limit
module riscv_dmem_timer
  import riscv_pkg::*;
#(
  parameter int W = DMEM_TMR_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         tc
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr)       count_d = '0;
    else if (load) count_d = load_val;
    else if (en)   count_d = count_q + W'(1);
  end

  // Look-ahead compare lets the owner leave on the same edge the count hits limit.
  assign tc = (count_q + W'(1)) == limit;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule

// File: rtl/riscv_dmem_ctrl.sv
// riscv_dmem_ctrl: MEM-stage word load/store responder.
//   clk, rst            : clock, synchronous active-high reset
//   mem_read, mem_write : request strobes from the MEM stage
//   addr, wdata         : byte address and store data
//   rdata               : load data, valid in DONE
//   stall               : holds IF/ID/EX/MEM until the access completes
//   err                 : one-cycle pulse in DONE on misalign/illegal/timeout
//   err_cause           : cause of the most recent error (debug)
//   bus                 : valid/ready data bus, master side
module riscv_dmem_ctrl
  import riscv_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata,
  output logic                  stall,
  output logic                  err,
  output err_cause_t            err_cause,
  riscv_dmem_ctrl_if.master     bus
);

  localparam logic [1:0] S_IDLE     = IDLE;
  localparam logic [1:0] S_REQ      = REQ;
  localparam logic [1:0] S_WAIT_RSP = WAIT_RSP;
  localparam logic [1:0] S_DONE     = DONE;

  logic [1:0]        state_q, state_d;
  logic              req_valid_q, req_valid_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  err_cause_t        cause_q, cause_d;

  logic req;
  logic tmr_clr, tmr_en, tmr_tc;

  assign req = mem_read | mem_write;

  riscv_dmem_timer #(.W(DMEM_TMR_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (tmr_clr),
    .load     (1'b0),
    .load_val ('0),
    .en       (tmr_en),
    .limit    (DMEM_TMR_W'(TIMEOUT)),
    .tc       (tmr_tc)
  );

  assign tmr_en = (state_q == S_REQ) || (state_q == S_WAIT_RSP);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    req_valid_d = req_valid_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    cause_d     = cause_q;
    tmr_clr     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (mem_read && mem_write) begin
            state_d = S_DONE;
            err_d   = 1'b1;
            rdata_d = '0;
            cause_d = CAUSE_ILLEGAL;
          end else if (is_misaligned(addr[1:0])) begin
            state_d = S_DONE;
            err_d   = 1'b1;
            rdata_d = '0;
            cause_d = CAUSE_MISALIGN;
          end else begin
            state_d     = S_REQ;
            req_valid_d = 1'b1;
            we_d        = mem_write;
            addr_d      = {addr[ADDR_W-1:2], 2'b00};
            wdata_d     = wdata;
            err_d       = 1'b0;
            tmr_clr     = 1'b1;
          end
        end
      end
      S_REQ: begin
        // Timeout wins over a same-cycle handshake: the counter would otherwise
        // run past its terminal value in WAIT_RSP and never fire.
        if (tmr_tc) begin
          state_d     = S_DONE;
          req_valid_d = 1'b0;
          err_d       = 1'b1;
          rdata_d     = '0;
          cause_d     = CAUSE_TIMEOUT;
        end else if (bus.bus_req_ready) begin
          state_d     = S_WAIT_RSP;
          req_valid_d = 1'b0;
        end
      end
      S_WAIT_RSP: begin
        // A response in the last allowed cycle still counts as success.
        if (bus.bus_rsp_valid) begin
          state_d = S_DONE;
          if (!we_q) rdata_d = bus.bus_rsp_rdata;
        end else if (tmr_tc) begin
          state_d = S_DONE;
          err_d   = 1'b1;
          rdata_d = '0;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      default: state_d = S_IDLE;  // DONE: one release cycle, never re-issues
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      req_valid_q <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      cause_q     <= CAUSE_NONE;
    end else begin
      state_q     <= state_d;
      req_valid_q <= req_valid_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      cause_q     <= cause_d;
    end
  end

  assign stall             = req && (state_q != S_DONE);
  assign err               = err_q && (state_q == S_DONE);
  assign err_cause         = cause_q;
  assign rdata             = rdata_q;
  assign bus.bus_req_valid = req_valid_q;
  assign bus.bus_we        = we_q;
  assign bus.bus_addr      = addr_q;
  assign bus.bus_wdata     = wdata_q;

endmodule

// File: tb/tb_riscv_dmem_ctrl.sv
// tb_riscv_dmem_ctrl: directed bench for riscv_dmem_ctrl with TIMEOUT=8.
module tb_riscv_dmem_ctrl;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [31:0] addr, wdata, rdata;
  logic        stall, err;
  err_cause_t  err_cause;

  int n_vec = 0;
  int n_err = 0;

  riscv_dmem_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

  riscv_dmem_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .stall     (stall),
    .err       (err),
    .err_cause (err_cause),
    .bus       (bus_if.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; addr = '0; wdata = '0;
    bus_if.bus_req_ready = 1'b0; bus_if.bus_rsp_valid = 1'b0; bus_if.bus_rsp_rdata = '0;
    tick(); tick();

    // Reset state
    check("rst_rdata", rdata, 32'h0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_stall", {31'b0, stall}, 32'd0);
    check("rst_valid", {31'b0, bus_if.bus_req_valid}, 32'd0);
    check("rst_we", {31'b0, bus_if.bus_we}, 32'd0);
    check("rst_addr", bus_if.bus_addr, 32'h0);
    check("rst_wdata", bus_if.bus_wdata, 32'h0);
    rst = 1'b0;
    tick();

    // Zero-wait read of 0x10
    mem_read = 1'b1; addr = 32'h10; bus_if.bus_req_ready = 1'b1; settle();
    check("rd_c0_stall", {31'b0, stall}, 32'd1);
    check("rd_c0_valid", {31'b0, bus_if.bus_req_valid}, 32'd0);
    tick();
    check("rd_c1_valid", {31'b0, bus_if.bus_req_valid}, 32'd1);
    check("rd_c1_addr", bus_if.bus_addr, 32'h10);
    check("rd_c1_we", {31'b0, bus_if.bus_we}, 32'd0);
    check("rd_c1_stall", {31'b0, stall}, 32'd1);
    tick();
    bus_if.bus_rsp_valid = 1'b1; bus_if.bus_rsp_rdata = 32'hDEADBEEF; settle();
    check("rd_c2_valid", {31'b0, bus_if.bus_req_valid}, 32'd0);
    check("rd_c2_stall", {31'b0, stall}, 32'd1);
    tick();
    bus_if.bus_rsp_valid = 1'b0; settle();
    check("rd_c3_stall", {31'b0, stall}, 32'd0);
    check("rd_c3_rdata", rdata, 32'hDEADBEEF);
    check("rd_c3_err", {31'b0, err}, 32'd0);
    mem_read = 1'b0;
    tick();

    // Write with 4 cycles of backpressure; a response during the handshake is ignored
    mem_write = 1'b1; addr = 32'h20; wdata = 32'h12345678; bus_if.bus_req_ready = 1'b0; settle();
    check("wr_c0_stall", {31'b0, stall}, 32'd1);
    tick();
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        bus_if.bus_req_ready = 1'b1; bus_if.bus_rsp_valid = 1'b1; bus_if.bus_rsp_rdata = 32'hBAD0BAD0;
      end
      settle();
      check("wr_hold_valid", {31'b0, bus_if.bus_req_valid}, 32'd1);
      check("wr_hold_addr", bus_if.bus_addr, 32'h20);
      check("wr_hold_wdata", bus_if.bus_wdata, 32'h12345678);
      check("wr_hold_we", {31'b0, bus_if.bus_we}, 32'd1);
      check("wr_hold_stall", {31'b0, stall}, 32'd1);
      tick();
    end
    bus_if.bus_req_ready = 1'b0; bus_if.bus_rsp_valid = 1'b0; settle();
    check("wr_wait_valid", {31'b0, bus_if.bus_req_valid}, 32'd0);
    check("wr_wait_stall", {31'b0, stall}, 32'd1);
    tick();
    check("wr_wait2_stall", {31'b0, stall}, 32'd1);
    bus_if.bus_rsp_valid = 1'b1;
    tick();
    bus_if.bus_rsp_valid = 1'b0; settle();
    check("wr_done_stall", {31'b0, stall}, 32'd0);
    check("wr_done_err", {31'b0, err}, 32'd0);
    check("wr_done_rdata", rdata, 32'hDEADBEEF);
    mem_write = 1'b0;
    tick();

    // Timeout: handshake, never respond, 8 cycles in REQ+WAIT_RSP
    mem_read = 1'b1; addr = 32'h30; bus_if.bus_req_ready = 1'b1; settle();
    check("to_c0_stall", {31'b0, stall}, 32'd1);
    tick();
    for (int i = 1; i <= 8; i++) begin
      check("to_stall", {31'b0, stall}, 32'd1);
      if (i == 1) check("to_c1_valid", {31'b0, bus_if.bus_req_valid}, 32'd1);
      if (i == 2) check("to_c2_valid", {31'b0, bus_if.bus_req_valid}, 32'd0);
      tick();
    end
    check("to_done_stall", {31'b0, stall}, 32'd0);
    check("to_done_err", {31'b0, err}, 32'd1);
    check("to_done_rdata", rdata, 32'h0);
    check("to_done_cause", 32'(err_cause), 32'(CAUSE_TIMEOUT));
    check("to_done_valid", {31'b0, bus_if.bus_req_valid}, 32'd0);
    mem_read = 1'b0; bus_if.bus_rsp_valid = 1'b1; bus_if.bus_rsp_rdata = 32'hCAFEF00D;
    tick();
    check("to_late1_rdata", rdata, 32'h0);
    check("to_late1_stall", {31'b0, stall}, 32'd0);
    tick();
    check("to_late2_rdata", rdata, 32'h0);
    check("to_late2_err", {31'b0, err}, 32'd0);
    check("to_late2_valid", {31'b0, bus_if.bus_req_valid}, 32'd0);
    bus_if.bus_rsp_valid = 1'b0;
    tick();

    // Misaligned read of 0x13
    mem_read = 1'b1; addr = 32'h13; settle();
    check("mis_c0_stall", {31'b0, stall}, 32'd1);
    check("mis_c0_valid", {31'b0, bus_if.bus_req_valid}, 32'd0);
    tick();
    check("mis_done_stall", {31'b0, stall}, 32'd0);
    check("mis_done_err", {31'b0, err}, 32'd1);
    check("mis_done_rdata", rdata, 32'h0);
    check("mis_done_valid", {31'b0, bus_if.bus_req_valid}, 32'd0);
    check("mis_done_cause", 32'(err_cause), 32'(CAUSE_MISALIGN));
    mem_read = 1'b0;
    tick();
    check("mis_after_err", {31'b0, err}, 32'd0);

    // Back-to-back reads: 0x44 then 0x48 presented right after DONE
    mem_read = 1'b1; addr = 32'h44; settle();
    tick();
    check("b2b_a_addr", bus_if.bus_addr, 32'h44);
    tick();
    bus_if.bus_rsp_valid = 1'b1; bus_if.bus_rsp_rdata = 32'h11112222;
    tick();
    bus_if.bus_rsp_valid = 1'b0; addr = 32'h48; settle();
    check("b2b_a_stall", {31'b0, stall}, 32'd0);
    check("b2b_a_rdata", rdata, 32'h11112222);
    tick();
    check("b2b_noreissue_valid", {31'b0, bus_if.bus_req_valid}, 32'd0);
    check("b2b_idle_stall", {31'b0, stall}, 32'd1);
    tick();
    check("b2b_b_valid", {31'b0, bus_if.bus_req_valid}, 32'd1);
    check("b2b_b_addr", bus_if.bus_addr, 32'h48);
    tick();
    bus_if.bus_rsp_valid = 1'b1; bus_if.bus_rsp_rdata = 32'h33334444;
    tick();
    bus_if.bus_rsp_valid = 1'b0; settle();
    check("b2b_b_rdata", rdata, 32'h33334444);
    check("b2b_b_stall", {31'b0, stall}, 32'd0);

    // Reset during WAIT_RSP, then a normal read of 0x40
    addr = 32'h50;
    tick();
    check("rm_idle_stall", {31'b0, stall}, 32'd1);
    tick();
    check("rm_req_valid", {31'b0, bus_if.bus_req_valid}, 32'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; addr = 32'h40; bus_if.bus_rsp_valid = 1'b1; bus_if.bus_rsp_rdata = 32'h99999999; settle();
    check("rm_valid", {31'b0, bus_if.bus_req_valid}, 32'd0);
    check("rm_rdata", rdata, 32'h0);
    check("rm_err", {31'b0, err}, 32'd0);
    check("rm_stall", {31'b0, stall}, 32'd1);
    tick();
    bus_if.bus_rsp_valid = 1'b0; settle();
    check("rm2_valid", {31'b0, bus_if.bus_req_valid}, 32'd1);
    check("rm2_addr", bus_if.bus_addr, 32'h40);
    check("rm2_rdata", rdata, 32'h0);
    tick();
    bus_if.bus_rsp_valid = 1'b1; bus_if.bus_rsp_rdata = 32'h5555AAAA;
    tick();
    bus_if.bus_rsp_valid = 1'b0; settle();
    check("rm2_done_rdata", rdata, 32'h5555AAAA);
    check("rm2_done_err", {31'b0, err}, 32'd0);
    check("rm2_done_stall", {31'b0, stall}, 32'd0);
    mem_read = 1'b0;
    tick();

    // Illegal: both strobes high
    mem_read = 1'b1; mem_write = 1'b1; addr = 32'h14; settle();
    check("ill_c0_stall", {31'b0, stall}, 32'd1);
    check("ill_c0_valid", {31'b0, bus_if.bus_req_valid}, 32'd0);
    tick();
    check("ill_done_stall", {31'b0, stall}, 32'd0);
    check("ill_done_err", {31'b0, err}, 32'd1);
    check("ill_done_rdata", rdata, 32'h0);
    check("ill_done_valid", {31'b0, bus_if.bus_req_valid}, 32'd0);
    check("ill_done_cause", 32'(err_cause), 32'(CAUSE_ILLEGAL));
    mem_read = 1'b0; mem_write = 1'b0;
    tick();
    check("ill_after_err", {31'b0, err}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
